// File: rtl/apb_regbank_pkg.sv
// apb_regbank_pkg: shared FSM state type, response codes and strobe helper for the APB register bank.
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;

    localparam int APB_MAX_DATA_W = 64;
    localparam int APB_MAX_STRB_W = APB_MAX_DATA_W / 8;

    // Sized for the widest supported bus; callers truncate to their own DATA_W.
    function automatic logic [APB_MAX_DATA_W-1:0] apb_strb_mask(input logic [APB_MAX_STRB_W-1:0] pstrb);
        logic [APB_MAX_DATA_W-1:0] mask;
        mask = {APB_MAX_DATA_W{1'b0}};
        for (int i = 0; i < APB_MAX_STRB_W; i++) begin
            mask[8*i +: 8] = {8{pstrb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_regbank_mem.sv
// apb_regbank_mem: DEPTH x DATA_W storage with a bit-masked write port and asynchronous read,
// cleared by the asynchronous reset.
module apb_regbank_mem
    import apb_regbank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array: masked read-modify-write of one word per cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_r[widx] <= (mem_r[widx] & ~wmask) | (wdata & wmask);
        end
    end

    assign rdata = mem_r[ridx];

endmodule

// File: rtl/apb_regbank.sv
// apb_regbank: parametrised APB completer register bank with byte strobes, wait states and error response.
// Define APB_PROT_CHECK_EN to reject unprivileged accesses to the lowest PRIV_WORDS words.
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
    parameter int                WAIT_CYC   = 0,
    parameter int                PRIV_WORDS = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [2:0]          prot,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic                slverr,
    output logic [DATA_W-1:0]   prdata
);

    localparam int                STRB_W     = DATA_W / 8;
    localparam int                LSB        = $clog2(STRB_W);
    localparam int                IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(DEPTH * STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
    localparam logic [4:0]        WAIT_EXT   = 5'(WAIT_CYC);

    apb_state_e          state_r;
    apb_state_e          phase_s;
    logic [3:0]          cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                write_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   strb_r;
    logic                pready_r;
    logic                slverr_r;
    logic [DATA_W-1:0]   prdata_r;

    logic [ADDR_W-1:0]   addr_s;
    logic                write_s;
    logic [ADDR_W-1:0]   off_s;
    logic [IDX_W-1:0]    idx_s;
    logic                hit_s;
    logic                priv_err_s;
    logic                err_s;
    logic                final_s;
    logic                we_s;
    logic [DATA_W-1:0]   wmask_s;
    logic [DATA_W-1:0]   rdata_s;

`ifdef APB_PROT_CHECK_EN
    logic priv_r;
    logic priv_s;
    logic unused_prot_s;
`else
    logic unused_prot_s;
`endif

    // The register only ever holds IDLE or ACCESS; SETUP is the cycle in which
    // the bus presents psel && !penable and the transfer is captured.
    always_comb begin
        phase_s = IDLE;
        if (state_r == ACCESS) begin
            if (!pready_r && psel && !penable) begin
                phase_s = SETUP;
            end else begin
                phase_s = ACCESS;
            end
        end else begin
            if (psel && !penable) begin
                phase_s = SETUP;
            end else begin
                phase_s = IDLE;
            end
        end
    end

    // Decode source: live bus during SETUP (zero-wait response), latched transfer otherwise.
    always_comb begin
        addr_s  = addr_r;
        write_s = write_r;
        if (phase_s == SETUP) begin
            addr_s  = paddr;
            write_s = pwrite;
        end else begin
            addr_s  = addr_r;
            write_s = write_r;
        end
    end

    assign off_s = addr_s - BASE_ADDR;
    assign idx_s = IDX_W'(off_s >> LSB);
    assign hit_s = (addr_s >= BASE_ADDR) && (off_s < SPAN) && ((off_s & ALIGN_MASK) == {ADDR_W{1'b0}});

`ifdef APB_PROT_CHECK_EN
    assign priv_s        = (phase_s == SETUP) ? prot[0] : priv_r;
    assign priv_err_s    = hit_s && (32'(idx_s) < PRIV_WORDS) && !priv_s;
    assign unused_prot_s = ^prot[2:1];
`else
    assign priv_err_s    = 1'b0;
    assign unused_prot_s = ^{prot, (PRIV_WORDS > 0)};
`endif

    assign err_s = !hit_s || priv_err_s;

    // Asserted when the coming edge enters the final (pready) ACCESS cycle.
    always_comb begin
        final_s = 1'b0;
        if (phase_s == SETUP) begin
            final_s = (WAIT_EXT == 5'd0);
        end else if (phase_s == ACCESS) begin
            final_s = !pready_r && psel && penable && (({1'b0, cnt_r} + 5'd1) == WAIT_EXT);
        end else begin
            final_s = 1'b0;
        end
    end

    assign we_s    = pready_r && write_r && !err_s;
    assign wmask_s = DATA_W'(apb_strb_mask(APB_MAX_STRB_W'(strb_r)));

    apb_regbank_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .nrst  (nrst),
        .we    (we_s),
        .widx  (idx_s),
        .wdata (wdata_r),
        .wmask (wmask_s),
        .ridx  (idx_s),
        .rdata (rdata_s)
    );

    // Transfer FSM, wait counter, latched transfer and registered response.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= {ADDR_W{1'b0}};
            write_r  <= 1'b0;
            wdata_r  <= {DATA_W{1'b0}};
            strb_r   <= {STRB_W{1'b0}};
            pready_r <= 1'b0;
            slverr_r <= APB_OKAY;
            prdata_r <= {DATA_W{1'b0}};
`ifdef APB_PROT_CHECK_EN
            priv_r   <= 1'b0;
`endif
        end else begin
            pready_r <= final_s;
            slverr_r <= (final_s && err_s) ? APB_SLVERR : APB_OKAY;
            prdata_r <= (final_s && !write_s && !err_s) ? rdata_s : {DATA_W{1'b0}};
            case (phase_s)
                SETUP: begin
                    state_r <= ACCESS;
                    cnt_r   <= 4'd0;
                    addr_r  <= paddr;
                    write_r <= pwrite;
                    wdata_r <= pwdata;
                    strb_r  <= pstrb;
`ifdef APB_PROT_CHECK_EN
                    priv_r  <= prot[0];
`endif
                end
                ACCESS: begin
                    if (pready_r || !psel) begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign pready = pready_r;
    assign slverr = slverr_r;
    assign prdata = prdata_r;

endmodule

// File: doc/apb_regbank.md
# apb_regbank

Parametrised APB slave register bank; next-generation replacement for the fixed 32-bit `apb_slave`. Provides `DEPTH` words of byte-strobed storage behind a standard APB3/APB4 completer port, with programmable wait states and error response. Sits directly behind the APB bridge as the peripheral under test in the existing `tb` environment (`my_apb_if`, `my_clk_if`), using the same signal names.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; multiple of 8, in 8..64.
- `DEPTH`, 16: number of data words; power of two, ≥2.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `DEPTH*DATA_W/8`.
- `WAIT_CYC`, 0: wait states inserted in ACCESS before `pready`; 0..15.
- `PRIV_WORDS`, 4: lowest N words are privileged; used only with `APB_PROT_CHECK_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `paddr`  in  ADDR_W  byte address.
- `prot`  in  3  protection; bit0 = privileged.
- `psel`  in  1  select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `pwdata`  in  DATA_W  write data.
- `pstrb`  in  DATA_W/8  write byte strobes.
- `pready`  out  1  transfer complete.
- `slverr`  out  1  error response; valid only with `pready`.
- `prdata`  out  DATA_W  read data; valid only with `pready` on reads.

## Operation

- FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP: `psel && !penable`.
  - SETUP→ACCESS: unconditional. Address, direction, data and strobes are latched on this edge.
  - ACCESS→IDLE: `pready` high, or `psel` low (abort).
  - ACCESS→SETUP: abort with `psel` high and `penable` low.
- `psel && penable` seen in IDLE (no setup phase) is ignored; the FSM stays in IDLE.
- Decode:
  - `idx = (paddr - BASE_ADDR) >> log2(DATA_W/8)`.
  - Hit when `paddr ≥ BASE_ADDR`, `idx < DEPTH`, and the low byte-offset bits are zero.
- A miss (out of range or misaligned) gives `slverr=1`, `prdata=0`, no state change.
- Write:
  - Byte lane i of `mem[idx]` takes `pwdata[8i+7:8i]` only when `pstrb[i]=1`.
  - All-zero `pstrb` is a legal no-op returning OKAY.
- Read: `prdata = mem[idx]`; `pstrb` is ignored.
- Reset:
  - All storage, `pready`, `slverr`, `prdata` are 0; FSM goes to IDLE; wait counter is 0.
  - Reset asserted mid-transfer discards the transfer; no partial write occurs.

## Timing

- Cycle S (SETUP): outputs stay 0.
- Wait counter clears on SETUP→ACCESS and increments each ACCESS cycle while `pready` is low.
- `pready` = (state==ACCESS) && (cnt==WAIT_CYC). It is a decode of registered state only, with no combinational path from inputs.
- With `WAIT_CYC=0`, `pready` is high in cycle S+1; in general it is high in cycle S+1+WAIT_CYC, for exactly one cycle.
- `prdata` and `slverr` are registered. They are loaded on the edge entering the final ACCESS cycle and cleared to 0 on the edge leaving it.
- Write commits on the rising edge that ends the `pready` cycle. A read in the next transfer returns the new value.
- Back-to-back transfers: when `psel` stays high and `penable` drops after `pready`, the next SETUP begins immediately. There is no dead cycle; throughput is one transfer per 2+WAIT_CYC cycles.
- If `psel` drops during ACCESS before `pready`, no write occurs and `pready` is never asserted for that transfer.

## Configuration

- `APB_PROT_CHECK_EN` defined:
  - A write to `idx < PRIV_WORDS` with `prot[0]=0` returns `slverr=1` and leaves storage unchanged.
  - Reads from those words with `prot[0]=0` return `slverr=1` and `prdata=0`.
- `APB_PROT_CHECK_EN` undefined:
  - `prot` is ignored and `PRIV_WORDS` has no effect.
  - No protection logic is synthesised.

## Structure

- Package `apb_regbank_pkg`:
  - FSM state enum `apb_state_e` (IDLE, SETUP, ACCESS).
  - Response constants `APB_OKAY` / `APB_SLVERR`.
  - Function `apb_strb_mask(pstrb)` expanding strobes to a bit mask.
- One sub-module, `apb_regbank_mem`: the DEPTH×DATA_W array with byte-enable write port and asynchronous read, reset to 0.
- FSM, decode, wait counter and protection check live in `apb_regbank`.

## Test plan

- Defaults: write `0xDEADBEEF` to `0x04` with `pstrb=4'hF`, then read `0x04` → `prdata=0xDEADBEEF`, `slverr=0`, `pready` one cycle after SETUP.
- Write `0xFFFFFFFF` to `0x08`, then write `0x00001234` with `pstrb=4'h3`, then read → `0xFFFF1234`.
- Read `0x40` (DEPTH=16, out of range) and read `0x06` (misaligned) → `slverr=1`, `prdata=0`, no storage change.
- `WAIT_CYC=2`: write to `0x0C` → `pready` low for 2 ACCESS cycles and high on the 3rd. A second transfer driven back-to-back starts SETUP in the next cycle.
- `APB_PROT_CHECK_EN`: write `0xA5A5A5A5` to `0x00` with `prot=3'b000` → `slverr=1`; read with `prot=3'b001` → `0x00000000`. Repeat the write with `prot=3'b001` → OKAY and reads back `0xA5A5A5A5`.
- Assert `nrst` low in the ACCESS phase of a write to `0x10` (`WAIT_CYC=2`) → `pready`, `slverr`, `prdata` go to 0 immediately; after release, read `0x10` → `0x00000000`.
